// File: rtl/nibble_mul_scheduler.sv
// nibble_mul_scheduler: two-requester round-robin front end for a shared
// combinational 4x4 multiplier. Each 8x8 request is split into four nibble
// partial products, issued one per cycle and accumulated into a 16-bit result.
// Optional feature: define NMS_ZERO_SKIP_EN to skip passes whose nibble
// operands contain a zero.
module nibble_mul_scheduler #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [7:0]  req0_a_i,
    input  logic [7:0]  req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [7:0]  req1_a_i,
    input  logic [7:0]  req1_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [15:0] rsp_p_o,
    output logic [3:0]  mul_a_o,
    output logic [3:0]  mul_b_o,
    input  logic [7:0]  mul_p_i,
    output logic        busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        id_q, id_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  pass_q, pass_d;

    logic        in_idle, in_mul, in_done;
    logic        gnt0, gnt1;
    logic [7:0]  cap_a, cap_b;
    logic [3:0]  cap_mask;
    logic [3:0]  run_mask;
    logic [15:0] pp_ext;
    logic [15:0] pp_shifted;
    logic [2:0]  nxt_first;
    logic [2:0]  nxt_after;

    // Lowest enabled pass index >= from; bit 2 flags that one exists.
    function automatic logic [2:0] first_pass(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // Round-robin grant; ready is forced low while reset is asserted.
    always_comb begin
        in_idle = (state_q == StIdle) && !rst_i;
        in_mul  = (state_q == StMul);
        in_done = (state_q == StDone);
        gnt0    = in_idle && req0_valid_i && (!req1_valid_i || !prio_q);
        gnt1    = in_idle && req1_valid_i && (!req0_valid_i || prio_q);
        cap_a   = gnt1 ? req1_a_i : req0_a_i;
        cap_b   = gnt1 ? req1_b_i : req0_b_i;
    end

`ifdef NMS_ZERO_SKIP_EN
    logic [3:0] mask_q;

    // A pass runs only when both of its nibble operands are non-zero.
    always_comb begin
        cap_mask = {(|cap_a[7:4]) & (|cap_b[7:4]),
                    (|cap_a[3:0]) & (|cap_b[7:4]),
                    (|cap_a[7:4]) & (|cap_b[3:0]),
                    (|cap_a[3:0]) & (|cap_b[3:0])};
        run_mask = mask_q;
    end

    // Pass mask is captured alongside the operands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= 4'h0;
        end else if (gnt0 || gnt1) begin
            mask_q <= cap_mask;
        end
    end
`else
    // All four passes always run.
    always_comb begin
        cap_mask = 4'hF;
        run_mask = 4'hF;
    end
`endif

    // Partial product aligned to its nibble weight.
    always_comb begin
        pp_ext     = {8'h00, mul_p_i};
        pp_shifted = pp_ext;
        unique case (pass_q)
            2'd0:    pp_shifted = pp_ext;
            2'd1:    pp_shifted = pp_ext << 4;
            2'd2:    pp_shifted = pp_ext << 4;
            default: pp_shifted = pp_ext << 8;
        endcase
    end

    // FSM next state, capture and accumulation.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        acc_d     = acc_q;
        pass_d    = pass_q;
        nxt_first = first_pass(cap_mask, 3'd0);
        nxt_after = first_pass(run_mask, {1'b0, pass_q} + 3'd1);
        case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    a_d   = cap_a;
                    b_d   = cap_b;
                    id_d  = gnt1;
                    acc_d = 16'h0000;
                    // Only a contested grant moves priority.
                    if (req0_valid_i && req1_valid_i) prio_d = ~prio_q;
                    if (nxt_first[2]) begin
                        pass_d  = nxt_first[1:0];
                        state_d = StMul;
                    end else begin
                        pass_d  = 2'd0;
                        state_d = StDone;
                    end
                end
            end
            StMul: begin
                acc_d = acc_q + pp_shifted;
                if (nxt_after[2]) begin
                    pass_d = nxt_after[1:0];
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            prio_q  <= (RR_INIT != 0);
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            id_q    <= 1'b0;
            acc_q   <= 16'h0000;
            pass_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs; multiplier operands and response fields are zero outside their states.
    always_comb begin
        req0_ready_o = gnt0;
        req1_ready_o = gnt1;
        rsp_valid_o  = in_done;
        rsp_p_o      = in_done ? acc_q : 16'h0000;
        rsp_id_o     = in_done & id_q;
        mul_a_o      = in_mul ? (pass_q[0] ? a_q[7:4] : a_q[3:0]) : 4'h0;
        mul_b_o      = in_mul ? (pass_q[1] ? b_q[7:4] : b_q[3:0]) : 4'h0;
        busy_o       = (state_q != StIdle);
    end

endmodule
